// File: rtl/qpi_psram_responder.sv
// rtl/qpi_psram_responder.sv - QPI PSRAM slave responder: SPI/QPI command decode, quad read and write to a byte memory
module qpi_psram_responder #(
  parameter int ADDR_W      = 23,
  parameter int WAIT_CYCLES = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_psram_csn,
  input  logic              i_psram_sclk,
  input  logic [3:0]        i_sio,
  output logic [3:0]        o_sio,
  output logic              o_sio_oe,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  output logic              o_qpi_mode,
  output logic [3:0]        o_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SPI_CMD = 4'd1,
    S_QPI_CMD = 4'd2,
    S_ADDR    = 4'd3,
    S_WAIT    = 4'd4,
    S_RD_DATA = 4'd5,
    S_WR_DATA = 4'd6,
    S_IGNORE  = 4'd7
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            r_state, w_state_n;
  logic              r_sclk_q;
  logic [3:0]        r_cnt, w_cnt_n;
  logic [7:0]        r_shift, w_shift_n;
  logic [ADDR_W-5:0] r_addr_sh, w_addr_sh_n;
  logic              r_is_read, w_is_read_n;
  logic              r_qpi, w_qpi_n;
  logic [3:0]        r_sio, w_sio_n;
  logic              r_oe, w_oe_n;
  logic              r_re, w_re_n;
  logic              r_we, w_we_n;
  logic [7:0]        r_wdata, w_wdata_n;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_n;
  logic [7:0]        r_cur, w_cur_n;
  logic              r_re_q;
  logic [7:0]        r_pf;

  logic              w_rise, w_fall;
  logic [7:0]        w_spi_byte, w_nib_byte;
  logic [ADDR_W-1:0] w_addr_full;

  assign w_rise      = ~r_sclk_q & i_psram_sclk;
  assign w_fall      = r_sclk_q & ~i_psram_sclk;
  assign w_spi_byte  = {r_shift[6:0], i_sio[1]};
  assign w_nib_byte  = {r_shift[3:0], i_sio};
  assign w_addr_full = {r_addr_sh, i_sio};

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_shift_n   = r_shift;
    w_addr_sh_n = r_addr_sh;
    w_is_read_n = r_is_read;
    w_qpi_n     = r_qpi;
    w_sio_n     = r_sio;
    w_oe_n      = r_oe;
    w_re_n      = 1'b0;
    w_we_n      = 1'b0;
    w_wdata_n   = r_wdata;
    w_addr_n    = r_mem_addr;
    w_cur_n     = r_cur;
    // Advance the address the cycle after a write so the strobe sees the target address.
    if (r_we) w_addr_n = r_mem_addr + ADDR_ONE;

    if (i_psram_csn) begin
      w_state_n = S_IDLE;
      w_cnt_n   = 4'd0;
      w_shift_n = 8'd0;
      w_oe_n    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_n = r_qpi ? S_QPI_CMD : S_SPI_CMD;
          w_cnt_n   = 4'd0;
        end
        S_SPI_CMD: if (w_rise) begin
          w_shift_n = w_spi_byte;
          w_cnt_n   = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            if (w_spi_byte == 8'h35) w_qpi_n = 1'b1;
            w_state_n = S_IGNORE;
            w_cnt_n   = 4'd0;
          end
        end
        S_QPI_CMD: if (w_rise) begin
          if (r_cnt == 4'd0) begin
            w_shift_n = {4'h0, i_sio};
            w_cnt_n   = 4'd1;
          end else begin
            w_cnt_n = 4'd0;
            case (w_nib_byte)
              8'hEB: begin w_state_n = S_ADDR; w_is_read_n = 1'b1; end
              8'h38: begin w_state_n = S_ADDR; w_is_read_n = 1'b0; end
              8'hF5: begin w_state_n = S_IGNORE; w_qpi_n = 1'b0; end
              default: w_state_n = S_IGNORE;
            endcase
          end
        end
        S_ADDR: if (w_rise) begin
          if (r_cnt == 4'd5) begin
            w_addr_n  = w_addr_full;
            w_cnt_n   = 4'd0;
            w_re_n    = r_is_read;
            w_state_n = r_is_read ? S_WAIT : S_WR_DATA;
          end else begin
            w_addr_sh_n = w_addr_full[ADDR_W-5:0];
            w_cnt_n     = r_cnt + 4'd1;
          end
        end
        S_WAIT: if (w_rise) begin
          if (r_cnt == WAIT_LAST) begin
            w_state_n = S_RD_DATA;
            w_cnt_n   = 4'd0;
          end else begin
            w_cnt_n = r_cnt + 4'd1;
          end
        end
        // The byte being shifted out is parked in r_cur so the prefetch can refill r_pf.
        S_RD_DATA: if (w_fall) begin
          w_oe_n = 1'b1;
          if (!r_cnt[0]) begin
            w_sio_n  = r_pf[7:4];
            w_cur_n  = r_pf;
            w_addr_n = r_mem_addr + ADDR_ONE;
            w_re_n   = 1'b1;
            w_cnt_n  = 4'd1;
          end else begin
            w_sio_n = r_cur[3:0];
            w_cnt_n = 4'd0;
          end
        end
        S_WR_DATA: if (w_rise) begin
          if (r_cnt == 4'd0) begin
            w_shift_n = {4'h0, i_sio};
            w_cnt_n   = 4'd1;
          end else begin
            w_we_n    = 1'b1;
            w_wdata_n = w_nib_byte;
            w_cnt_n   = 4'd0;
          end
        end
        S_IGNORE: w_oe_n = 1'b0;
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_sclk_q   <= 1'b0;
      r_cnt      <= 4'd0;
      r_shift    <= 8'd0;
      r_addr_sh  <= '0;
      r_is_read  <= 1'b0;
      r_qpi      <= 1'b0;
      r_sio      <= 4'd0;
      r_oe       <= 1'b0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= 8'd0;
      r_mem_addr <= '0;
      r_cur      <= 8'd0;
      r_re_q     <= 1'b0;
      r_pf       <= 8'd0;
    end else begin
      r_state    <= w_state_n;
      r_sclk_q   <= i_psram_sclk;
      r_cnt      <= w_cnt_n;
      r_shift    <= w_shift_n;
      r_addr_sh  <= w_addr_sh_n;
      r_is_read  <= w_is_read_n;
      r_qpi      <= w_qpi_n;
      r_sio      <= w_sio_n;
      r_oe       <= w_oe_n;
      r_re       <= w_re_n;
      r_we       <= w_we_n;
      r_wdata    <= w_wdata_n;
      r_mem_addr <= w_addr_n;
      r_cur      <= w_cur_n;
      r_re_q     <= r_re;
      if (r_re_q) r_pf <= i_mem_rdata;
    end
  end

  assign o_sio       = r_sio;
  assign o_sio_oe    = r_oe;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_re    = r_re;
  assign o_mem_we    = r_we;
  assign o_mem_wdata = r_wdata;
  assign o_qpi_mode  = r_qpi;
  assign o_state     = r_state;

endmodule

// File: tb/tb_qpi_psram_responder.sv
// tb/tb_qpi_psram_responder.sv - table-driven and randomized bench for qpi_psram_responder
module tb_qpi_psram_responder;
  localparam int AW = 23;
  localparam int WC = 6;

  logic          clk = 1'b0;
  logic          rst, csn, sclk;
  logic [3:0]    sio_in;
  logic [3:0]    o_sio;
  logic          o_sio_oe;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [7:0]    mem_rdata = 8'h00;
  logic [7:0]    mem_wdata;
  logic          qpi_mode;
  logic [3:0]    state;

  qpi_psram_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .i_clk(clk), .i_rst(rst), .i_psram_csn(csn), .i_psram_sclk(sclk),
    .i_sio(sio_in), .o_sio(o_sio), .o_sio_oe(o_sio_oe),
    .o_mem_addr(mem_addr), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata),
    .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .o_qpi_mode(qpi_mode), .o_state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Backing memory: synchronous read, unwritten locations follow a fixed pattern.
  logic [7:0] mem [int];
  function automatic logic [7:0] pat(input int a);
    return 8'(a ^ (a >> 8) ^ 8'h3C);
  endfunction

  always @(posedge clk)
    if (mem_re) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : pat(int'(mem_addr));

  int nre = 0, nwe = 0, strobe_bad = 0;
  logic prev_re = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] wlog_a [$];
  logic [7:0]    wlog_d [$];
  always @(negedge clk) begin
    if (mem_we) begin
      mem[int'(mem_addr)] = mem_wdata;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
      nwe++;
    end
    if (mem_re) nre++;
    if ((mem_re && mem_we) || (mem_re && prev_re) || (mem_we && prev_we)) strobe_bad++;
    prev_re = mem_re;
    prev_we = mem_we;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_cycle(input logic [3:0] v, output logic [3:0] so, output logic oe);
    sio_in = v;
    sclk = 1'b0;
    tick(3);
    so = o_sio;
    oe = o_sio_oe;
    sclk = 1'b1;
    tick(3);
  endtask

  // op 0: SPI byte, 1: QPI command only, 2: QPI write, 3: QPI read
  task automatic txn(input int op, input logic [7:0] code, input logic [23:0] addr,
                     input int nnib, input logic [35:0] nibs,
                     output logic [31:0] rd, output int oe_bad);
    logic [3:0] so;
    logic oe;
    rd = 32'h0;
    oe_bad = 0;
    csn = 1'b0;
    tick(2);
    if (op == 0) begin
      for (int i = 7; i >= 0; i--) sclk_cycle({2'b00, code[i], 1'b0}, so, oe);
    end else begin
      sclk_cycle(code[7:4], so, oe);
      sclk_cycle(code[3:0], so, oe);
      if (op >= 2)
        for (int k = 5; k >= 0; k--) sclk_cycle(addr[4*k +: 4], so, oe);
      if (op == 2)
        for (int i = 0; i < nnib; i++) sclk_cycle(nibs[35-4*i -: 4], so, oe);
      if (op == 3) begin
        for (int i = 0; i < WC; i++) sclk_cycle(4'h0, so, oe);
        for (int i = 0; i < nnib; i++) begin
          sclk_cycle(4'h0, so, oe);
          rd = {rd[27:0], so};
          if (!oe) oe_bad++;
        end
      end
    end
    csn = 1'b1;
    tick(1);
    if (op == 3 && o_sio_oe) oe_bad++;
    sclk = 1'b0;
    tick(3);
  endtask

  typedef struct {
    int          op;
    logic [7:0]  code;
    logic [23:0] addr;
    int          nnib;
    logic [35:0] nibs;
    logic        exp_qpi;
    int          exp_nwe;
    logic        exp_re;
    logic [22:0] wa0;
    logic [7:0]  wd0;
    logic [22:0] wa1;
    logic [7:0]  wd1;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input int op, input logic [7:0] code, input logic [23:0] addr,
                              input int nnib, input logic [35:0] nibs, input logic q, input int nw,
                              input logic re, input logic [22:0] wa0, input logic [7:0] wd0,
                              input logic [22:0] wa1, input logic [7:0] wd1, input logic [31:0] rd);
    vec_t v;
    v.op = op; v.code = code; v.addr = addr; v.nnib = nnib; v.nibs = nibs;
    v.exp_qpi = q; v.exp_nwe = nw; v.exp_re = re;
    v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.exp_rd = rd;
    return v;
  endfunction

  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_rd(input logic [22:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(int'(a));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [31:0] rd, exp_rd;
    logic [3:0]  so;
    logic        oe;
    int          oe_bad, re0, we0, n, kind;
    logic [23:0] a24;
    logic [35:0] nibs;
    logic [7:0]  code, b;
    logic [22:0] a;
    logic        model_qpi;
    logic [22:0] ea [$];
    logic [7:0]  ed [$];

    vecs[0] = mk(0, 8'h35, 24'h0,      0, 36'h0,         1'b1, 0, 1'b0, 23'h0,      8'h0,  23'h0,  8'h0,  32'h0);
    vecs[1] = mk(2, 8'h38, 24'h000010, 4, 36'hA53C00000, 1'b1, 2, 1'b0, 23'h10,     8'hA5, 23'h11, 8'h3C, 32'h0);
    vecs[2] = mk(3, 8'hEB, 24'h000020, 4, 36'h0,         1'b1, 0, 1'b1, 23'h0,      8'h0,  23'h0,  8'h0,  32'h1234);
    vecs[3] = mk(2, 8'h38, 24'h7FFFFF, 5, 36'h112250000, 1'b1, 2, 1'b0, 23'h7FFFFF, 8'h11, 23'h0,  8'h22, 32'h0);
    vecs[4] = mk(1, 8'h9F, 24'h0,      0, 36'h0,         1'b1, 0, 1'b0, 23'h0,      8'h0,  23'h0,  8'h0,  32'h0);
    vecs[5] = mk(1, 8'hF5, 24'h0,      0, 36'h0,         1'b0, 0, 1'b0, 23'h0,      8'h0,  23'h0,  8'h0,  32'h0);
    vecs[6] = mk(0, 8'hEB, 24'h0,      0, 36'h0,         1'b0, 0, 1'b0, 23'h0,      8'h0,  23'h0,  8'h0,  32'h0);
    vecs[7] = mk(0, 8'h35, 24'h0,      0, 36'h0,         1'b1, 0, 1'b0, 23'h0,      8'h0,  23'h0,  8'h0,  32'h0);

    mem[32'h20] = 8'h12;
    mem[32'h21] = 8'h34;

    rst = 1'b1; csn = 1'b1; sclk = 1'b0; sio_in = 4'h0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_qpi", 32'(qpi_mode), 32'd0);
    chk("rst_oe", 32'(o_sio_oe), 32'd0);
    chk("rst_sio", 32'(o_sio), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);

    for (int v = 0; v < 8; v++) begin
      re0 = nre; we0 = nwe;
      wlog_a.delete(); wlog_d.delete();
      txn(vecs[v].op, vecs[v].code, vecs[v].addr, vecs[v].nnib, vecs[v].nibs, rd, oe_bad);
      chk($sformatf("vec%0d_qpi", v), 32'(qpi_mode), 32'(vecs[v].exp_qpi));
      chk($sformatf("vec%0d_nwe", v), 32'(nwe - we0), 32'(vecs[v].exp_nwe));
      chk($sformatf("vec%0d_re", v), 32'(nre != re0), 32'(vecs[v].exp_re));
      if (vecs[v].exp_nwe >= 2 && wlog_a.size() >= 2) begin
        chk($sformatf("vec%0d_wa0", v), 32'(wlog_a[0]), 32'(vecs[v].wa0));
        chk($sformatf("vec%0d_wd0", v), 32'(wlog_d[0]), 32'(vecs[v].wd0));
        chk($sformatf("vec%0d_wa1", v), 32'(wlog_a[1]), 32'(vecs[v].wa1));
        chk($sformatf("vec%0d_wd1", v), 32'(wlog_d[1]), 32'(vecs[v].wd1));
      end
      if (vecs[v].op == 3) begin
        chk($sformatf("vec%0d_rd", v), rd, vecs[v].exp_rd);
        chk($sformatf("vec%0d_oe", v), 32'(oe_bad), 32'd0);
      end
    end

    // Reset in the middle of a read burst.
    csn = 1'b0;
    tick(2);
    sclk_cycle(4'hE, so, oe);
    sclk_cycle(4'hB, so, oe);
    for (int k = 5; k >= 0; k--) sclk_cycle(4'(24'h000020 >> (4*k)), so, oe);
    for (int i = 0; i < WC + 3; i++) sclk_cycle(4'h0, so, oe);
    rst = 1'b1;
    tick(1);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_qpi", 32'(qpi_mode), 32'd0);
    chk("midrst_oe_sio", {27'd0, o_sio_oe, o_sio}, 32'd0);
    chk("midrst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("midrst_addr_wdata", {1'b0, mem_addr, mem_wdata}, 32'd0);
    rst = 1'b0;
    csn = 1'b1;
    tick(3);
    sclk = 1'b0;
    tick(3);

    // A QPI-style read after reset must be decoded as SPI bits.
    re0 = nre;
    csn = 1'b0;
    tick(2);
    sclk_cycle(4'hE, so, oe);
    sclk_cycle(4'hB, so, oe);
    for (int k = 5; k >= 0; k--) sclk_cycle(4'(24'h000020 >> (4*k)), so, oe);
    chk("postrst_state", 32'(state), 32'd7);
    csn = 1'b1;
    tick(3);
    sclk = 1'b0;
    tick(3);
    chk("postrst_qpi", 32'(qpi_mode), 32'd0);
    chk("postrst_nre", 32'(nre - re0), 32'd0);

    // Randomized traffic against the reference memory model.
    mem.delete();
    ref_mem.delete();
    txn(0, 8'h35, 24'h0, 0, 36'h0, rd, oe_bad);
    model_qpi = 1'b1;
    chk("rand_entry_qpi", 32'(qpi_mode), 32'(model_qpi));
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      a24 = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a24[22:0] = 23'h7FFFFF - 23'($urandom_range(0, 2));
      re0 = nre; we0 = nwe;
      wlog_a.delete(); wlog_d.delete();
      if (kind <= 3) begin
        n = $urandom_range(0, 9);
        nibs = 36'({$urandom, $urandom});
        ea.delete(); ed.delete();
        for (int i = 0; i < n / 2; i++) begin
          a = a24[22:0] + 23'(i);
          b = {nibs[35-8*i -: 4], nibs[31-8*i -: 4]};
          ea.push_back(a);
          ed.push_back(b);
          ref_mem[int'(a)] = b;
        end
        txn(2, 8'h38, a24, n, nibs, rd, oe_bad);
        chk($sformatf("rand%0d_nwe", it), 32'(nwe - we0), 32'(n / 2));
        for (int i = 0; i < n / 2 && i < wlog_a.size(); i++) begin
          chk($sformatf("rand%0d_wa%0d", it, i), 32'(wlog_a[i]), 32'(ea[i]));
          chk($sformatf("rand%0d_wd%0d", it, i), 32'(wlog_d[i]), 32'(ed[i]));
        end
      end else if (kind <= 7) begin
        n = $urandom_range(1, 8);
        exp_rd = 32'h0;
        for (int i = 0; i < n; i++) begin
          b = ref_rd(a24[22:0] + 23'(i / 2));
          exp_rd = {exp_rd[27:0], (i % 2 == 0) ? b[7:4] : b[3:0]};
        end
        txn(3, 8'hEB, a24, n, 36'h0, rd, oe_bad);
        chk($sformatf("rand%0d_rd", it), rd, exp_rd);
        chk($sformatf("rand%0d_oe", it), 32'(oe_bad), 32'd0);
        chk($sformatf("rand%0d_nwe", it), 32'(nwe - we0), 32'd0);
      end else if (kind == 8) begin
        code = 8'($urandom);
        while (code == 8'hEB || code == 8'h38 || code == 8'hF5) code = code + 8'd1;
        txn(1, code, 24'h0, 0, 36'h0, rd, oe_bad);
        chk($sformatf("rand%0d_unk_strobes", it), 32'((nre - re0) + (nwe - we0)), 32'd0);
      end else begin
        txn(1, 8'hF5, 24'h0, 0, 36'h0, rd, oe_bad);
        model_qpi = 1'b0;
        chk($sformatf("rand%0d_exit_qpi", it), 32'(qpi_mode), 32'(model_qpi));
        txn(0, 8'h35, 24'h0, 0, 36'h0, rd, oe_bad);
        model_qpi = 1'b1;
      end
      chk($sformatf("rand%0d_qpi", it), 32'(qpi_mode), 32'(model_qpi));
    end

    chk("strobe_overlap_or_width", 32'(strobe_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qpi_psram_responder.md
QPI_PSRAM_RESPONDER -- requirements
Module: qpi_psram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, the number of byte-address bits forwarded to the backing memory.
REQ-002 SHALL have parameter WAIT_CYCLES, default 6, the number of dummy sclk rising edges in a fast-quad-read (EBh); legal range is 1..15.
REQ-003 Ports:
- i_clk, input, 1 bit: system clock.
- i_rst, input, 1 bit: reset.
- i_psram_csn, input, 1 bit: chip select, active low.
- i_psram_sclk, input, 1 bit: serial clock, generated in the i_clk domain.
- i_sio, input, 4 bits: SIO[3:0] sampled from the pad.
- o_sio, output, 4 bits: SIO drive value.
- o_sio_oe, output, 1 bit: SIO output enable.
- o_mem_addr, output, ADDR_W bits: backing-memory byte address.
- o_mem_re, output, 1 bit: read strobe.
- i_mem_rdata, input, 8 bits: read data, valid exactly 1 i_clk after o_mem_re.
- o_mem_we, output, 1 bit: write strobe.
- o_mem_wdata, output, 8 bits: write data.
- o_qpi_mode, output, 1 bit: QPI mode flag.
- o_state, output, 4 bits: current FSM state code.
REQ-004 The block SHALL use one clock, i_clk; i_rst SHALL be synchronous and active-high.

Function
REQ-005 SHALL register i_psram_sclk once each i_clk; a rising edge is (sclk_q=0, sclk=1) and a falling edge is (sclk_q=1, sclk=0); all sampling and driving SHALL occur only on these detected edges.
REQ-006 States and codes: IDLE=0, SPI_CMD=1, QPI_CMD=2, ADDR=3, WAIT=4, RD_DATA=5, WR_DATA=6, IGNORE=7.
REQ-007 Whenever i_psram_csn=1, the block SHALL go to IDLE, clear the bit/nibble counters, drive o_sio_oe=0 on the next i_clk, and discard any partial byte; o_qpi_mode SHALL be kept.
REQ-008 IDLE: on the first i_clk with csn=0, SHALL go to SPI_CMD if o_qpi_mode=0, else to QPI_CMD.
REQ-009 SPI_CMD: SHALL shift i_sio[1] in MSB-first on 8 rising edges.
- Byte 35h: set o_qpi_mode=1 and go to IGNORE.
- Any other byte: go to IGNORE.
REQ-010 QPI_CMD: SHALL take 2 nibbles, high nibble first.
- EBh or 38h: go to ADDR.
- F5h: clear o_qpi_mode and go to IGNORE.
- Any other value: go to IGNORE.
REQ-011 ADDR: SHALL capture 6 nibbles, A[23:20] first; o_mem_addr SHALL equal A[ADDR_W-1:0].
- For EBh: pulse o_mem_re for 1 i_clk on the i_clk after the 6th nibble, latch i_mem_rdata 1 i_clk later, then go to WAIT.
- For 38h: go to WR_DATA.
REQ-012 WAIT: SHALL count WAIT_CYCLES rising edges, then go to RD_DATA.
REQ-013 RD_DATA: on each falling edge SHALL set o_sio_oe=1 and drive the next nibble, high nibble first, starting at the first falling edge after the last WAIT rising edge.
- When the high nibble is driven, SHALL increment o_mem_addr and pulse o_mem_re (prefetch).
- When the low nibble is driven, SHALL load the prefetched byte for the next pair.
- Reading SHALL continue until csn rises.
REQ-014 WR_DATA: SHALL assemble byte pairs, high nibble first.
- On the low-nibble rising edge: pulse o_mem_we for 1 i_clk with o_mem_wdata = byte at the current o_mem_addr, then increment o_mem_addr.
- A lone trailing nibble SHALL produce no write.
REQ-015 IGNORE: SHALL hold o_sio_oe=0 and ignore sclk until csn rises.
REQ-016 o_mem_addr SHALL wrap from 2^ADDR_W-1 to 0.
REQ-017 o_mem_re and o_mem_we SHALL never be asserted in the same cycle; each SHALL be a single-cycle pulse.
REQ-018 o_sio_oe SHALL be 1 only in RD_DATA with csn=0.

Reset
REQ-019 i_rst=1 SHALL set the following on the next i_clk, overriding any transfer in progress:
- state=IDLE
- o_qpi_mode=0
- o_sio=0, o_sio_oe=0
- o_mem_re=0, o_mem_we=0
- o_mem_addr=0, o_mem_wdata=0
- all counters=0
REQ-020 After reset, the block SHALL require a new 35h SPI command before QPI commands are accepted.

Verification
REQ-021 Mode entry: csn low, SPI bits 0,0,1,1,0,1,0,1 on SIO1, csn high -> o_qpi_mode=1; no mem strobes.
REQ-022 Write: QPI 38h, addr 000010h, data nibbles A,5,3,C -> o_mem_we twice: (0x10, A5h) then (0x11, 3Ch).
REQ-023 Read: memory 0x20=12h, 0x21=34h; QPI EBh, addr 000020h, 6 dummy clocks, 4 data clocks -> o_sio sequence 1,2,3,4 with oe=1; oe=0 within 1 i_clk after csn rises.
REQ-024 Wrap and abort: 38h at address 2^ADDR_W-1 with bytes 11h,22h plus one extra nibble -> writes at 7FFFFFh then 000000h; extra nibble is dropped.
REQ-025 Unknown command and reset: QPI 9Fh -> IGNORE with no strobes; i_rst mid-read -> all outputs at reset values and o_qpi_mode=0; a QPI EBh afterward is treated as SPI bits (no read).
